// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures period/high time of a clk-synchronous divided signal,
// declares ratio lock after LOCK_CNT good periods, and flags mismatches/stalls.
module div_clk_monitor #(
  parameter int EXP_HIGH = 2,
  parameter int EXP_LOW  = 2,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 16,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          div_in,
  input  logic          err_clr,
  output logic [CW-1:0] period_o,
  output logic [CW-1:0] high_o,
  output logic          meas_vld,
  output logic          locked,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, LOCKED} state_t;
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [CW-1:0] EXP_P = CW'(EXP_HIGH + EXP_LOW);
  localparam logic [CW-1:0] EXP_H = CW'(EXP_HIGH);
  localparam logic [CW-1:0] TOUT  = CW'(TIMEOUT);
  localparam logic [MW-1:0] LCNT  = MW'(LOCK_CNT);

  state_t        state_q, state_d;
  logic          d1_q, vld_q, vld_d, err_q, err_d, err_set;
  logic [CW-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d, period_q, period_d, high_q, high_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic          rise, match, stall;

  assign rise  = div_in & ~d1_q;
  assign match = (cnt_q == EXP_P) && (hcnt_q == EXP_H);
  assign stall = cnt_q == TOUT;

  always_comb begin
    state_d  = state_q;
    cnt_d    = rise ? CW'(1) : (cnt_q == CMAX ? cnt_q : cnt_q + 1'b1);
    hcnt_d   = rise ? CW'(1) : (div_in && hcnt_q != CMAX ? hcnt_q + 1'b1 : hcnt_q);
    mcnt_d   = mcnt_q;
    period_d = period_q;
    high_d   = high_q;
    vld_d    = 1'b0;
    err_set  = 1'b0;
    if (!en || state_q == IDLE) begin
      state_d = en ? WAIT_EDGE : IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
      mcnt_d  = '0;
    end else if (state_q == WAIT_EDGE) begin
      state_d = rise ? MEASURE : WAIT_EDGE;
    end else if (rise) begin
      period_d = cnt_q;
      high_d   = hcnt_q;
      vld_d    = 1'b1;
      if (!match) begin
        mcnt_d  = '0;
        err_set = 1'b1;
        state_d = MEASURE;
      end else if (state_q == MEASURE) begin
        mcnt_d  = mcnt_q + 1'b1;
        state_d = (mcnt_q + 1'b1 == LCNT) ? LOCKED : MEASURE;
      end
    end else if (stall) begin
      // divider stopped toggling: restart from edge acquisition, no measurement
      err_set = 1'b1;
      mcnt_d  = '0;
      cnt_d   = '0;
      hcnt_d  = '0;
      state_d = WAIT_EDGE;
    end
    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      d1_q     <= 1'b0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      mcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      d1_q     <= div_in;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      mcnt_q   <= mcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
    end
  end

  assign period_o = period_q;
  assign high_o   = high_q;
  assign meas_vld = vld_q;
  assign locked   = state_q == LOCKED;
  assign err      = err_q;
endmodule

// File: doc/div_clk_monitor.md
# div_clk_monitor

Downstream checker for the divide-by-4 stage: it consumes the divided output (`po_cnt`) as a data signal in the source `clk` domain. For each period it measures the length and the high time in `clk` cycles. It declares lock after a run of periods that match the expected ratio, and raises a sticky error on a ratio mismatch or a stalled divider. It is used in simulation and silicon bring-up to prove that the divider runs at the intended ratio and duty cycle.

## Interface
- `EXP_HIGH`, default 2: expected high cycles per period.
- `EXP_LOW`, default 2: expected low cycles per period. Expected period is `EXP_HIGH+EXP_LOW`.
- `LOCK_CNT`, default 4: consecutive matching periods required to assert lock. Must be ≥1.
- `TIMEOUT`, default 16: cycles without a rising edge before the stall error fires. Must be greater than the expected period.
- `CW`, default 8: width of the measurement counters. Must satisfy `2^CW-1 ≥ TIMEOUT`.
- `clk`, in, 1: single clock. Also clocks the divider feeding `div_in`.
- `rst`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: monitor enable, level sensitive.
- `div_in`, in, 1: divided clock, synchronous to `clk`. Connects to `po_cnt`.
- `err_clr`, in, 1: one-cycle pulse that clears `err`.
- `period_o`, out, CW: last measured period, in cycles.
- `high_o`, out, CW: last measured high time, in cycles.
- `meas_vld`, out, 1: one-cycle pulse when `period_o`/`high_o` are updated.
- `locked`, out, 1: ratio lock indicator.
- `err`, out, 1: sticky error flag.

## Operation
- `div_in` is already synchronous to `clk`, so there is no synchronizer. It passes through a single delay register `d1`.
- `rise = div_in & ~d1`.
- `cnt` (CW bits):
  - loads 1 on `rise`;
  - otherwise increments, saturating at `2^CW-1`.
- `hcnt` (CW bits):
  - loads 1 on `rise`;
  - otherwise increments when `div_in`=1, saturating.
- At a rise, `cnt` therefore holds the rising-to-rising distance and `hcnt` holds the high cycles in that period.
- State machine:
  - **IDLE**: counters held at 0; `locked`=0. Goes to WAIT_EDGE when `en`=1.
  - **WAIT_EDGE**: waits for the first `rise`, which starts counting but produces no measurement. Goes to MEASURE on `rise`.
  - **MEASURE**: on every `rise`, captures `period_o<=cnt` and `high_o<=hcnt`, and pulses `meas_vld`.
    - A capture matches when `cnt==EXP_HIGH+EXP_LOW` and `hcnt==EXP_HIGH`.
    - Match: `mcnt` increments. Reaching `LOCK_CNT` moves to LOCKED and sets `locked`.
    - Mismatch: `mcnt<=0` and `err<=1`; the state stays MEASURE.
  - **LOCKED**: keeps measuring. A mismatch clears `locked` and `mcnt`, sets `err`, and returns to MEASURE.
- Stall: in MEASURE or LOCKED, if `cnt` reaches `TIMEOUT` with no `rise`:
  - `err<=1` and `locked<=0`;
  - `mcnt` and the counters clear;
  - the state goes to WAIT_EDGE;
  - `meas_vld` does not pulse.
- `en`=0 in any state returns to IDLE on the next edge and clears `locked`, `mcnt` and the counters. `period_o`, `high_o` and `err` hold their values.
- `err_clr` clears `err` on the next edge. If an error event occurs in the same cycle, the set wins.
- Reset asserted mid-operation returns everything to its reset state immediately, regardless of `clk`.

## Timing
- Reset values: `period_o`=0, `high_o`=0, `meas_vld`=0, `locked`=0, `err`=0, state IDLE, `d1`=0.
- `rise` is combinational from `div_in` sampled in cycle t.
- `period_o`, `high_o`, `meas_vld`, `locked` and the mismatch `err` are registered and visible in cycle t+1.
- `meas_vld` is high for exactly one cycle per accepted period.
- Stall `err` appears the cycle after `cnt==TIMEOUT` is registered.
- `locked` rises in the same cycle as the `meas_vld` of the `LOCK_CNT`-th consecutive match. With the defaults this is the 5th rising edge after `en`: one edge to start, four matches.
- First `rise` after reset release: if `div_in`=1 on the first cycle, it counts as a rise because `d1` resets to 0.

## Test plan
- **Nominal lock:** defaults, 20 ns clock, release `rst` at 50 ns with `en`=1, `div_in` = 2 high / 2 low -> `meas_vld` every 4 cycles with `period_o`=4 and `high_o`=2; `locked`=1 after the 5th rise; `err`=0 throughout.
- **Duty error:** after lock, one period of 3 high / 1 low -> `period_o`=4, `high_o`=3, `locked` drops the next cycle, `err`=1; `locked` regained after 4 further good periods while `err` stays 1 until `err_clr`.
- **Stall:** after lock, hold `div_in`=0 -> `err`=1 and `locked`=0 the cycle after `cnt`=16; no `meas_vld`; resuming 2/2 gives lock 5 rises later.
- **Simultaneous clear and error:** pulse `err_clr` in the same cycle as a mismatch capture -> `err` remains 1. `err_clr` alone -> `err`=0 the next cycle.
- **Enable drop:** deassert `en` while locked -> `locked`=0 the next cycle; `period_o` holds 4; re-enable -> WAIT_EDGE, and the first rise yields no `meas_vld`.
- **Async reset mid-period:** assert `rst` low between clock edges while locked -> all outputs 0 immediately, without waiting for a `clk` edge.
